serial_magnitude_comparator: RTL and testbench
==============================================

// Module: serial_magnitude_comparator
//
// PURPOSE
// Sequential, bit-serial counterpart of the parallel 4-bit magnitude comparator.
// Latches two unsigned operands on a start request and scans them MSB-first, one
// bit per clock. Terminates early on the first differing bit.
// Reports A>B / A<B / A=B with a one-cycle done pulse, for area-constrained
// datapaths that can trade latency for logic.
//
// PARAMETERS
// WIDTH    4    operand width in bits (>= 2); also the worst-case compare latency
//
// PORTS
// clk      in   1      single clock; all state updates on rising edge
// rst      in   1      synchronous, active-high reset
// start    in   1      compare request; accepted only when busy=0
// a_in     in   WIDTH  operand A, unsigned; sampled on the accepting edge only
// b_in     in   WIDTH  operand B, unsigned; sampled on the accepting edge only
// busy     out  1      high while a compare is in progress
// done     out  1      one-cycle pulse; flags valid from this cycle
// a_gt_b   out  1      A > B result flag
// a_lt_b   out  1      A < B result flag
// a_eq_b   out  1      A == B result flag
//
// BEHAVIOUR
// - Reset (rst=1 at an edge): state=IDLE; busy, done, a_gt_b, a_lt_b and a_eq_b all 0.
//   Shift registers and bit counter are cleared. Reset overrides start.
// - FSM states: IDLE, SCAN. All outputs are registered.
// - IDLE, start=1 at an edge:
//   - latch a_in/b_in into shift regs; bit_cnt <= WIDTH-1; busy <= 1.
//   - clear all three flags; go to SCAN.
// - IDLE, start=0: hold; done <= 0; flags hold their last result.
// - SCAN, at each edge, compare a_sh[MSB] vs b_sh[MSB]:
//   - bits differ: set a_gt_b=a_sh[MSB], a_lt_b=b_sh[MSB], a_eq_b=0.
//     Then done<=1, busy<=0, go to IDLE.
//   - bits equal and bit_cnt==0: set a_eq_b=1, done<=1, busy<=0, go to IDLE.
//   - bits equal, bit_cnt>0: shift both regs left by 1; bit_cnt--; stay in SCAN.
// - Latency: with k = 0-based index from the MSB of the first differing bit,
//   done goes high k+1 edges after the accepting edge. For equal operands this is
//   WIDTH edges. Minimum 1, maximum WIDTH.
// - done is high for exactly 1 cycle. While done=1, exactly one flag is high.
//   Flags hold until the next start is accepted. While busy=1, all flags are 0.
// - start while busy=1 is ignored: no re-latch, no queueing, in-flight compare unaffected.
// - start in the cycle done=1: state is IDLE, so it is accepted (back-to-back).
//   That edge deasserts done and clears the flags.
// - a_in/b_in changes while busy have no effect.
// - rst during SCAN aborts the compare; no done pulse, flags read 0.
//
// TESTING
// 1. Reset, then start A=0000 B=0000: busy for 4 cycles; done on 4th edge; eq=1 gt=0 lt=0.
// 2. A=1010 B=1001: done 3 edges after start; gt=1, lt=0, eq=0.
// 3. A=0111 B=1110: done 1 edge after start (MSB differs); lt=1, gt=0, eq=0.
// 4. A=1100 B=1100: done after 4 edges; eq=1. Flags stay stable over 5 idle cycles after done.
// 5. Start A=0001 B=0000; pulse start with A=1111 B=0000 one cycle later.
//    -> second request ignored; done after 4 edges with gt=1, reflecting only the first operands.
// 6. Start A=0010 B=0011; assert rst on 2nd SCAN cycle.
//    -> no done pulse; all outputs 0. A following start with A=1000 B=0111 gives gt=1 after 1 edge.

Source files
------------

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator: scans MSB-first and stops on the first differing bit.
// Latency 1..WIDTH cycles from the accepting edge; start is ignored while busy (no queueing).
module serial_magnitude_comparator #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;

  logic a_msb, b_msb;
  assign a_msb = a_sh_q[WIDTH-1];
  assign b_msb = b_sh_q[WIDTH-1];

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    bit_cnt_d = bit_cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    gt_d      = gt_q;
    lt_d      = lt_q;
    eq_d      = eq_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d    = a_in;
          b_sh_d    = b_in;
          bit_cnt_d = CW'(WIDTH - 1);
          busy_d    = 1'b1;
          gt_d      = 1'b0;
          lt_d      = 1'b0;
          eq_d      = 1'b0;
          state_d   = SCAN;
        end
      end

      SCAN: begin
        if (a_msb != b_msb) begin
          // The first differing bit alone decides the ordering.
          gt_d    = a_msb;
          lt_d    = b_msb;
          eq_d    = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (bit_cnt_q == '0) begin
          eq_d    = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          a_sh_d    = {a_sh_q[WIDTH-2:0], 1'b0};
          b_sh_d    = {b_sh_q[WIDTH-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q - CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
      eq_q      <= eq_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign a_gt_b = gt_q;
  assign a_lt_b = lt_q;
  assign a_eq_b = eq_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator: vector table plus hand-written multi-cycle sequences.
module tb_serial_magnitude_comparator;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         busy, done, a_gt_b, a_lt_b, a_eq_b;

  always #5 clk = ~clk;

  serial_magnitude_comparator #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .a_gt_b (a_gt_b),
    .a_lt_b (a_lt_b),
    .a_eq_b (a_eq_b)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         gt;
    logic         lt;
    logic         eq;
    int           lat;
  } vec_t;

  typedef struct {
    logic gt;
    logic lt;
    logic eq;
    int   lat;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[7];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic gt, input logic lt, input logic eq, input int lat);
    exp_t e;
    e.gt = gt; e.lt = lt; e.eq = eq; e.lat = lat;
    return e;
  endfunction

  // Drive one start; on return we are 1 time unit after the accepting edge.
  task automatic start_cmp(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input exp_t e);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    check({name, ".accept"}, {busy, done, a_gt_b, a_lt_b, a_eq_b}, 5'b10000);
  endtask

  // Wait for done, counting edges since the accepting edge; compare against scoreboard head.
  task automatic wait_done(input string name, input int already);
    int   n;
    bit   seen;
    exp_t e;
    seen = 1'b0;
    n    = already;
    while (!seen && n < W + 3) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1'b1;
    end
    if (sb.size() == 0) begin
      check({name, ".sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      if (!seen) begin
        check({name, ".timeout"}, 0, 1);
      end else begin
        check({name, ".latency"}, n, e.lat);
        check({name, ".flags"}, {a_gt_b, a_lt_b, a_eq_b}, {e.gt, e.lt, e.eq});
        check({name, ".busy_at_done"}, busy, 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] flags_at_done;
    bit         stable;
    bit         saw_done;

    tbl[0] = '{a: 4'b0000, b: 4'b0000, gt: 1'b0, lt: 1'b0, eq: 1'b1, lat: 4};
    tbl[1] = '{a: 4'b1010, b: 4'b1001, gt: 1'b1, lt: 1'b0, eq: 1'b0, lat: 3};
    tbl[2] = '{a: 4'b0111, b: 4'b1110, gt: 1'b0, lt: 1'b1, eq: 1'b0, lat: 1};
    tbl[3] = '{a: 4'b1100, b: 4'b1100, gt: 1'b0, lt: 1'b0, eq: 1'b1, lat: 4};
    tbl[4] = '{a: 4'b0110, b: 4'b0101, gt: 1'b1, lt: 1'b0, eq: 1'b0, lat: 3};
    tbl[5] = '{a: 4'b1111, b: 4'b1110, gt: 1'b1, lt: 1'b0, eq: 1'b0, lat: 4};
    tbl[6] = '{a: 4'b0100, b: 4'b0110, gt: 1'b0, lt: 1'b1, eq: 1'b0, lat: 3};

    rst = 1'b1; start = 1'b1; a_in = 4'b1111; b_in = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset.outputs", {busy, done, a_gt_b, a_lt_b, a_eq_b}, 5'b00000);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("reset.idle_hold", {busy, done, a_gt_b, a_lt_b, a_eq_b}, 5'b00000);

    for (int i = 0; i < 7; i++) begin
      start_cmp($sformatf("vec%0d", i), tbl[i].a, tbl[i].b,
                mk(tbl[i].gt, tbl[i].lt, tbl[i].eq, tbl[i].lat));
      wait_done($sformatf("vec%0d", i), 0);
      flags_at_done = {a_gt_b, a_lt_b, a_eq_b};
      stable = 1'b1;
      for (int c = 0; c < 5; c++) begin
        @(posedge clk); #1;
        if ({a_gt_b, a_lt_b, a_eq_b} != flags_at_done || done || busy) stable = 1'b0;
      end
      check($sformatf("vec%0d.idle_stable", i), stable, 1);
    end

    // Back-to-back: start asserted in the done cycle is accepted.
    start_cmp("b2b.first", 4'b1010, 4'b1001, mk(1'b1, 1'b0, 1'b0, 3));
    wait_done("b2b.first", 0);
    start_cmp("b2b.second", 4'b0111, 4'b1110, mk(1'b0, 1'b1, 1'b0, 1));
    wait_done("b2b.second", 0);

    // Start while busy is ignored; operand changes while busy have no effect.
    start_cmp("busy_start", 4'b0001, 4'b0000, mk(1'b1, 1'b0, 1'b0, 4));
    a_in  = 4'b1111;
    b_in  = 4'b0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_in  = 4'b0000;
    b_in  = 4'b1111;
    check("busy_start.no_early_done", {busy, done}, 2'b10);
    wait_done("busy_start", 1);

    // Reset during scan aborts the compare without a done pulse.
    start_cmp("abort", 4'b0010, 4'b0011, mk(1'b0, 1'b0, 1'b0, 0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort.outputs", {busy, done, a_gt_b, a_lt_b, a_eq_b}, 5'b00000);
    saw_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("abort.no_done", saw_done, 0);
    void'(sb.pop_front());
    start_cmp("after_abort", 4'b1000, 4'b0111, mk(1'b1, 1'b0, 1'b0, 1));
    wait_done("after_abort", 0);
    @(posedge clk); #1;
    check("after_abort.done_pulse", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
